// File: rtl/load_store_unit.sv
// Load/store unit: turns one core access into at most one word-aligned bus request,
// with lane steering, load extension, alignment checks and a REQ/WAIT timeout.
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbg_state
);

   // Handshakes: a core access transfers when req_valid && req_ready; a bus request
   // transfers when mem_valid && mem_ready; read data is taken only when mem_rvalid
   // is high while waiting for it. resp_valid is a one-cycle pulse.

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          op_write;
   logic [1:0]    op_size;
   logic          op_uns;
   logic [31:0]   op_addr;
   logic [31:0]   op_wdata;

   logic [31:0]   rsp_data_q;
   logic          rsp_err_q;

   logic          latch_req;
   logic          rsp_set;
   logic          rsp_err_d;
   logic [31:0]   rsp_data_d;

   logic          req_bad;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   load_ext;
   logic [3:0]    store_strb;
   logic [31:0]   store_data;

   // Illegal size or a half/word address that does not sit on its natural boundary.
   always_comb begin
      req_bad = 1'b0;
      case (req_size)
         2'b00:   req_bad = 1'b0;
         2'b01:   req_bad = req_addr[0];
         2'b10:   req_bad = |req_addr[1:0];
         default: req_bad = 1'b1;
      endcase
   end

   always_comb begin
      byte_sel = 8'(mem_rdata >> {op_addr[1:0], 3'b000});
      half_sel = 16'(mem_rdata >> {op_addr[1], 4'b0000});
      load_ext = mem_rdata;
      case (op_size)
         2'b00:   load_ext = {{24{~op_uns & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~op_uns & half_sel[15]}}, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   always_comb begin
      store_strb = 4'b1111;
      store_data = op_wdata;
      case (op_size)
         2'b00: begin
            store_strb = 4'b0001 << op_addr[1:0];
            store_data = {4{op_wdata[7:0]}};
         end
         2'b01: begin
            store_strb = 4'b0011 << {op_addr[1], 1'b0};
            store_data = {2{op_wdata[15:0]}};
         end
         default: begin
            store_strb = 4'b1111;
            store_data = op_wdata;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A completing event in the same cycle as the last counted cycle still wins,
   // except a load handshake, which would leave no cycle for the read return.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      latch_req  = 1'b0;
      rsp_set    = 1'b0;
      rsp_err_d  = 1'b0;
      rsp_data_d = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               latch_req = 1'b1;
               cnt_d     = '0;
               if (req_bad) begin
                  state_d   = RESP;
                  rsp_set   = 1'b1;
                  rsp_err_d = 1'b1;
               end else begin
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (mem_ready && op_write) begin
               state_d = RESP;
               rsp_set = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = RESP;
               rsp_set   = 1'b1;
               rsp_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (mem_ready) state_d = WAIT;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_d    = RESP;
               rsp_set    = 1'b1;
               rsp_data_d = load_ext;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = RESP;
               rsp_set   = 1'b1;
               rsp_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_write <= 1'b0;
         op_size  <= 2'b00;
         op_uns   <= 1'b0;
         op_addr  <= '0;
         op_wdata <= '0;
      end else if (latch_req) begin
         op_write <= req_write;
         op_size  <= req_size;
         op_uns   <= req_unsigned;
         op_addr  <= req_addr;
         op_wdata <= req_wdata;
      end
   end

   // Response data and error persist after the pulse until the next completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else if (rsp_set) begin
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rsp_data_q;
   assign resp_error = rsp_err_q;

   // Bus outputs are zero outside REQ so an idle or reset unit drives a quiet bus.
   assign mem_valid  = (state_q == REQ);
   assign mem_write  = mem_valid & op_write;
   assign mem_addr   = mem_valid ? {op_addr[31:2], 2'b00} : '0;
   assign mem_wstrb  = mem_write ? store_strb : 4'b0000;
   assign mem_wdata  = mem_write ? store_data : '0;

   assign dbg_state  = state_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles spent in REQ plus WAIT before the access is aborted.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the core presents an access.
REQ-005 SHALL have port req_ready, output, 1 bit: the unit accepts the access; high only in IDLE.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_unsigned, input, 1 bit: zero-extend load data (lbu/lhu).
REQ-009 SHALL have ports req_addr and req_wdata, input, 32 bits each: byte address and store data (data in the low bits).
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-012 SHALL have port resp_error, output, 1 bit: misaligned, illegal size or timeout; valid with resp_valid.
REQ-013 SHALL have ports mem_valid, output, 1 bit, and mem_ready, input, 1 bit: bus request handshake.
REQ-014 SHALL have ports mem_write, output, 1 bit; mem_addr, output, 32 bits (word-aligned, [1:0] = 00); mem_wstrb, output, 4 bits; mem_wdata, output, 32 bits.
REQ-015 SHALL have ports mem_rvalid, input, 1 bit, and mem_rdata, input, 32 bits: read return.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-017 IDLE, on req_valid: latch all req_* inputs; legal and aligned -> REQ; otherwise -> RESP with error set and no bus access.
REQ-018 Misalignment SHALL be: half with addr[0] = 1; word with addr[1:0] != 00.
REQ-019 REQ: mem_valid = 1 with mem_* stable until mem_ready; on the handshake, store -> RESP and load -> WAIT.
REQ-020 WAIT: on mem_rvalid, capture and extend the data -> RESP; mem_rvalid seen in any other state SHALL be ignored.
REQ-021 The timeout counter SHALL clear on entry to REQ and count every cycle in REQ or WAIT.
REQ-022 When the counter reaches TIMEOUT: -> RESP with error; mem_valid drops without a handshake.
REQ-023 RESP: resp_valid = 1 for exactly one cycle, then -> IDLE; back-to-back requests are accepted on the following cycle.
REQ-024 Store strobe: byte = 0001 << addr[1:0]; half = 0011 << (2*addr[1]); word = 1111.
REQ-025 Store data: byte = 4 copies of wdata[7:0]; half = 2 copies of wdata[15:0]; word = wdata.
REQ-026 Load data: byte lane = rdata >> 8*addr[1:0], then bits [7:0]; half lane = rdata >> 16*addr[1], then bits [15:0].
REQ-027 Load extension: sign-extend unless req_unsigned; word loads pass through.
REQ-028 Loads SHALL drive mem_wstrb = 0000.
REQ-029 Best-case latency from accept to resp_valid: store 2 cycles; load 3 cycles (mem_ready in the first REQ cycle, mem_rvalid in the first WAIT cycle); error 1 cycle.
REQ-030 resp_rdata and resp_error SHALL hold their value until the next RESP.

Reset
REQ-031 rst SHALL immediately force IDLE, clear the counter, and zero all outputs except req_ready, which is 1.
REQ-032 rst mid-access SHALL abandon the access with no resp_valid; a late mem_rvalid after reset SHALL be ignored.

Verification
REQ-033 lb at addr 0x103, mem_rdata 0x80FF_0000 -> mem_addr 0x100, resp_rdata 0xFFFF_FF80, 3 cycles.
REQ-034 sh at addr 0x202, wdata 0x0000_BEEF -> mem_wstrb 1100, mem_wdata 0xBEEF_BEEF, mem_write = 1, resp_valid 2 cycles after accept.
REQ-035 lw at addr 0x201 -> resp_error = 1 one cycle after accept, mem_valid never asserted.
REQ-036 lhu at 0x002, mem_ready delayed 5 cycles, rdata 0x9ABC_0000 -> mem_* stable during the stall, resp_rdata 0x0000_9ABC.
REQ-037 Load with mem_rvalid never asserted, TIMEOUT = 8 -> resp_error = 1 at cycle 9 of REQ/WAIT.
REQ-038 rst pulsed during WAIT, then mem_rvalid -> IDLE, no resp_valid, req_ready = 1.
